// File: rtl/cpu_pkg.sv
// Shared constants and fetch-state encoding for the 16-bit pipeline.
// Decode and the PC-adder stage use the same bubble encoding.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;
  localparam logic [15:0] RESET_PC  = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  // Instructions are one 16-bit word, so sequential PCs step by 2 and wrap at 2^16.
  function automatic logic [15:0] pc_incr(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

  function automatic logic [15:0] pc_align(input logic [15:0] addr);
    return {addr[15:1], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: flush beats stall, stall beats load,
// and with nothing to load it inserts a bubble.
module if_id_reg #(
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stall,
  input  logic        load,
  input  logic [15:0] load_pc,
  input  logic [15:0] load_instr,
  output logic        valid,
  output logic [15:0] pc,
  output logic [15:0] instr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      pc    <= 16'h0000;
      instr <= NOP_INSTR;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (stall) begin
      valid <= valid;
      pc    <= pc;
      instr <= instr;
    end else if (load) begin
      valid <= 1'b1;
      pc    <= load_pc;
      instr <= load_instr;
    end else begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues held read requests to
// instruction memory and feeds the IF/ID register.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter logic [15:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic        if_valid,
  output logic [15:0] if_pc,
  output logic [15:0] if_instr
);

  fetch_state_t state, state_nx;
  logic [15:0]  pc, pc_nx;
  logic [15:0]  target, target_nx;
  logic [15:0]  buf_word, buf_pc;
  logic         buf_cap;
  logic         load;
  logic [15:0]  load_pc, load_instr;
  logic [15:0]  redirect_tgt;

  assign redirect_tgt = pc_align(redirect_pc);

  // The request and address stay put until the memory answers; only HOLD drops the request.
  assign imem_req  = (state != HOLD);
  assign imem_addr = pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      target   <= 16'h0000;
      buf_word <= NOP_INSTR;
      buf_pc   <= 16'h0000;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      target <= target_nx;
      if (buf_cap) begin
        buf_word <= imem_rdata;
        buf_pc   <= pc;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    target_nx  = target;
    buf_cap    = 1'b0;
    load       = 1'b0;
    load_pc    = pc;
    load_instr = imem_rdata;
    unique case (state)
      FETCH: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_nx = redirect_tgt;
          end else if (stall) begin
            buf_cap  = 1'b1;
            state_nx = HOLD;
          end else begin
            load  = 1'b1;
            pc_nx = pc_incr(pc);
          end
        end else if (redirect) begin
          target_nx = redirect_tgt;
          state_nx  = DRAIN;
        end
      end
      // The in-flight read must complete before the target can be fetched; its word is dropped.
      DRAIN: begin
        if (redirect) begin
          target_nx = redirect_tgt;
        end
        if (imem_ready) begin
          pc_nx    = redirect ? redirect_tgt : target;
          state_nx = FETCH;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nx    = redirect_tgt;
          state_nx = FETCH;
        end else if (!stall) begin
          load       = 1'b1;
          load_pc    = buf_pc;
          load_instr = buf_word;
          pc_nx      = pc_incr(pc);
          state_nx   = FETCH;
        end
      end
      default: state_nx = FETCH;
    endcase
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .stall     (stall),
    .load      (load),
    .load_pc   (load_pc),
    .load_instr(load_instr),
    .valid     (if_valid),
    .pc        (if_pc),
    .instr     (if_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: a behavioural model predicts every
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        stall = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        if_valid;
  logic [15:0] if_pc;
  logic [15:0] if_instr;

  fetch_stage dut (
    .clk        (clk),
    .rst        (rst),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .stall      (stall),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_instr   (if_instr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        req;
    logic [15:0] addr;
    logic        v;
    logic [15:0] pc;
    logic [15:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: architectural PC, an optional parked word, an optional
  // pending redirect behind an in-flight read, and the IF/ID contents.
  bit          m_known = 0;
  logic [15:0] m_pc;
  bit          m_parked;
  logic [15:0] m_park_word, m_park_pc;
  bit          m_pending;
  logic [15:0] m_pend_tgt;
  bit          m_v;
  logic [15:0] m_ifpc, m_ifinstr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic model_step(input bit r, input bit rd, input logic [15:0] rpc,
                            input bit st, input bit rdy, input logic [15:0] word);
    bit          got;
    logic [15:0] got_pc, got_word, tgt;
    tgt = rpc & 16'hFFFE;
    if (r) begin
      m_known = 1; m_pc = 16'h0000; m_parked = 0; m_pending = 0; m_pend_tgt = 16'h0000;
      m_v = 0; m_ifpc = 16'h0000; m_ifinstr = 16'h0800;
      return;
    end
    got = 0; got_pc = 16'h0000; got_word = 16'h0000;
    if (m_parked) begin
      if (rd) begin
        m_parked = 0; m_pc = tgt;
      end else if (!st) begin
        got = 1; got_pc = m_park_pc; got_word = m_park_word;
        m_parked = 0; m_pc = m_pc + 16'd2;
      end
    end else if (m_pending) begin
      if (rd) m_pend_tgt = tgt;
      if (rdy) begin
        m_pc = m_pend_tgt; m_pending = 0;
      end
    end else if (rdy) begin
      if (rd) m_pc = tgt;
      else if (st) begin
        m_parked = 1; m_park_word = word; m_park_pc = m_pc;
      end else begin
        got = 1; got_pc = m_pc; got_word = word; m_pc = m_pc + 16'd2;
      end
    end else if (rd) begin
      m_pending = 1; m_pend_tgt = tgt;
    end
    if (rd) begin
      m_v = 0; m_ifinstr = 16'h0800;
    end else if (st) begin
      // outputs hold
    end else if (got) begin
      m_v = 1; m_ifpc = got_pc; m_ifinstr = got_word;
    end else begin
      m_v = 0; m_ifinstr = 16'h0800;
    end
  endtask

  task automatic cycle(input bit r, input bit rd, input logic [15:0] rpc,
                       input bit st, input bit rdy);
    exp_t        e;
    logic [15:0] word;
    if (m_known) begin
      e.req = !m_parked; e.addr = m_pc; e.v = m_v; e.pc = m_ifpc; e.instr = m_ifinstr;
      exp_q.push_back(e);
    end
    word = mem_word(m_pc);
    rst = r; redirect = rd; redirect_pc = rpc; stall = st; imem_ready = rdy;
    imem_rdata = rdy ? word : 16'($urandom);
    @(posedge clk);
    model_step(r, rd, rpc, st, rdy, word);
    #1;
  endtask

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check16("imem_req", {15'd0, imem_req}, {15'd0, e.req});
      if (e.req) check16("imem_addr", imem_addr, e.addr);
      check16("if_valid", {15'd0, if_valid}, {15'd0, e.v});
      check16("if_pc", if_pc, e.pc);
      check16("if_instr", if_instr, e.instr);
    end
  end

  initial begin
    bit r, rd, st, rdy;
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    // zero-wait fetches at 0 and 2
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // three wait states at pc=4, then 4 and 6 complete
    repeat (3) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // stall as the word at pc=8 returns, held for a second cycle
    cycle(0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    // redirect to 0x40 while pc=12 waits
    cycle(0, 1, 16'h0040, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // redirect and stall together, with odd target
    cycle(0, 1, 16'h0081, 1, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // wrap at 0xFFFE
    cycle(0, 1, 16'hFFFE, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // reset in the middle of a drain
    cycle(0, 1, 16'h0100, 0, 0);
    cycle(1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    // stall with nothing outstanding, then redirect out of a parked word
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 16'h0200, 1, 0);
    cycle(0, 0, 0, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 4) == 0);
      rdy = !m_parked && ($urandom_range(0, 9) < 6);
      cycle(r, rd, 16'($urandom), st, rdy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
